data_loop_controller: RTL

- Downstream neighbour of the main controller; one run per input-depth pass.
- On each data-prepare request, sweeps all spatial tiles of the current input channel in row-major order.
- Per tile, streams per-word SRAM read addresses to the Winograd PE array over a valid/ready handshake, then waits for the PE's tile-done.
- After the last tile, returns a one-cycle loop-finished pulse to the main controller and re-arms.

---
 rtl/data_loop_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/data_loop_controller.sv
// data_loop_controller: sweeps the spatial tiles of one input-channel plane in
// row-major order, streaming per-word read addresses to the Winograd PE array
// and pacing tiles on the PE's tile-done. Addresses are built with adders only;
// the products needed (plane base, row stride, tile-row stride) are formed once
// when the sweep parameters are captured.
module data_loop_controller #(
   parameter int ADDR_W      = 16,
   parameter int PLANE_WORDS = 3600
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_prepare_i,
   input  logic [7:0]        block_width_i,
   input  logic [7:0]        block_height_i,
   input  logic [3:0]        data_id_i,
   input  logic              size_type_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic              rd_last_o,
   output logic [7:0]        tile_x_o,
   output logic [7:0]        tile_y_o,
   input  logic              tile_done_i,
   output logic              busy_o,
   output logic              loop_finished_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_PE = 3'd2,
      ST_DONE    = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t            state_r;
   logic [7:0]        width_r, height_r, tx_r, ty_r;
   logic [2:0]        tdim_r, col_r, row_r;
   logic [ADDR_W-1:0] stride_r, tile_row_stride_r, tile_step_r;
   logic [ADDR_W-1:0] tile_row_base_r, tile_base_r, row_base_r, addr_r;
   logic              valid_r, last_r, busy_r, finished_r;

   logic [7:0]        width_eff_s, height_eff_s;
   logic [2:0]        tdim_s, tdim_m1_s;
   logic [ADDR_W-1:0] stride_s, tile_row_stride_s, plane_base_s;
   logic [ADDR_W-1:0] next_row_base_s, next_tile_base_s;
   logic              col_end_s, row_end_s, row_wrap_s, last_tile_s;

   // Sweep parameters derived from the request inputs, used only at capture.
   always_comb begin
      width_eff_s       = (block_width_i == 8'd0) ? 8'd1 : block_width_i;
      height_eff_s      = (block_height_i == 8'd0) ? 8'd1 : block_height_i;
      tdim_s            = size_type_i ? 3'd4 : 3'd6;
      stride_s          = ADDR_W'(32'(width_eff_s) * 32'(tdim_s));
      tile_row_stride_s = ADDR_W'(32'(width_eff_s) * 32'(tdim_s) * 32'(tdim_s));
      plane_base_s      = ADDR_W'(32'(data_id_i) * 32'(PLANE_WORDS));
   end

   // Position flags and the start address of the following tile.
   always_comb begin
      tdim_m1_s        = tdim_r - 3'd1;
      col_end_s        = (col_r == tdim_m1_s);
      row_end_s        = (row_r == tdim_m1_s);
      row_wrap_s       = (tx_r == (width_r - 8'd1));
      last_tile_s      = row_wrap_s && (ty_r == (height_r - 8'd1));
      next_row_base_s  = tile_row_base_r + tile_row_stride_r;
      if (row_wrap_s) begin
         next_tile_base_s = next_row_base_s;
      end else begin
         next_tile_base_s = tile_base_r + tile_step_r;
      end
   end

   // Sweep state machine with all outputs held in registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r           <= ST_IDLE;
         width_r           <= 8'd0;
         height_r          <= 8'd0;
         tx_r              <= 8'd0;
         ty_r              <= 8'd0;
         tdim_r            <= 3'd0;
         col_r             <= 3'd0;
         row_r             <= 3'd0;
         stride_r          <= '0;
         tile_row_stride_r <= '0;
         tile_step_r       <= '0;
         tile_row_base_r   <= '0;
         tile_base_r       <= '0;
         row_base_r        <= '0;
         addr_r            <= '0;
         valid_r           <= 1'b0;
         last_r            <= 1'b0;
         busy_r            <= 1'b0;
         finished_r        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (data_prepare_i) begin
                  width_r           <= width_eff_s;
                  height_r          <= height_eff_s;
                  tdim_r            <= tdim_s;
                  stride_r          <= stride_s;
                  tile_row_stride_r <= tile_row_stride_s;
                  tile_step_r       <= ADDR_W'(tdim_s);
                  tile_row_base_r   <= plane_base_s;
                  tile_base_r       <= plane_base_s;
                  row_base_r        <= plane_base_s;
                  addr_r            <= plane_base_s;
                  tx_r              <= 8'd0;
                  ty_r              <= 8'd0;
                  col_r             <= 3'd0;
                  row_r             <= 3'd0;
                  last_r            <= 1'b0;
                  valid_r           <= 1'b1;
                  busy_r            <= 1'b1;
                  state_r           <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (rd_ready_i) begin
                  if (col_end_s && row_end_s) begin
                     valid_r <= 1'b0;
                     last_r  <= 1'b0;
                     state_r <= ST_WAIT_PE;
                  end else if (col_end_s) begin
                     col_r      <= 3'd0;
                     row_r      <= row_r + 3'd1;
                     row_base_r <= row_base_r + stride_r;
                     addr_r     <= row_base_r + stride_r;
                     last_r     <= 1'b0;
                  end else begin
                     col_r  <= col_r + 3'd1;
                     addr_r <= addr_r + ADDR_W'(1'b1);
                     last_r <= row_end_s && (col_r == (tdim_r - 3'd2));
                  end
               end
            end
            ST_WAIT_PE: begin
               if (tile_done_i) begin
                  if (last_tile_s) begin
                     tx_r       <= 8'd0;
                     ty_r       <= 8'd0;
                     finished_r <= 1'b1;
                     state_r    <= ST_DONE;
                  end else begin
                     if (row_wrap_s) begin
                        tx_r            <= 8'd0;
                        ty_r            <= ty_r + 8'd1;
                        tile_row_base_r <= next_row_base_s;
                     end else begin
                        tx_r <= tx_r + 8'd1;
                     end
                     tile_base_r <= next_tile_base_s;
                     row_base_r  <= next_tile_base_s;
                     addr_r      <= next_tile_base_s;
                     col_r       <= 3'd0;
                     row_r       <= 3'd0;
                     last_r      <= 1'b0;
                     valid_r     <= 1'b1;
                     state_r     <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               finished_r <= 1'b0;
               busy_r     <= 1'b0;
               state_r    <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // The request level is still the one that started this sweep;
               // only a low level re-arms the block.
               if (!data_prepare_i) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               valid_r    <= 1'b0;
               last_r     <= 1'b0;
               busy_r     <= 1'b0;
               finished_r <= 1'b0;
               tx_r       <= 8'd0;
               ty_r       <= 8'd0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_addr_o       = addr_r;
   assign rd_valid_o      = valid_r;
   assign rd_last_o       = last_r;
   assign tile_x_o        = tx_r;
   assign tile_y_o        = ty_r;
   assign busy_o          = busy_r;
   assign loop_finished_o = finished_r;

endmodule
